// File: rtl/calc_display.sv
// Receiving end of the calculator digit stream: captures, double-buffers and scans 8 seven-segment digits.
// Optional leading-zero blanking is enabled by defining CALC_DISPLAY_ZERO_BLANK_EN.
module calc_display #(
  parameter int SCAN_DIV       = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] status,
  input  logic [3:0] data,
  input  logic [3:0] pos,
  output logic [6:0] seg,
  output logic [7:0] an,
  output logic       frame_done,
  output logic       frame_err,
  output logic       err_led
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PRESC_PENULT = PW'(SCAN_DIV - 2);
  localparam logic [6:0] SEG_BLANK_OUT = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [7:0] AN_OFF_OUT    = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
`ifdef CALC_DISPLAY_ZERO_BLANK_EN
  localparam logic [7:0] BLANK_RESET = 8'hFE;
`else
  localparam logic [7:0] BLANK_RESET = 8'h00;
`endif

  typedef enum logic {
    SCAN_HOLD,
    SCAN_NEXT
  } scan_state_t;

  logic [3:0]    r_shadow [8];
  logic [3:0]    r_disp   [8];
  logic [7:0]    r_blank;
  logic [7:0]    r_wmask;
  logic [1:0]    r_prevStatus;
  logic [2:0]    r_scanIdx;
  logic [PW-1:0] r_prescaler;
  scan_state_t   r_scanState;
  logic          r_errLatched;
  logic [6:0]    r_seg;
  logic [7:0]    r_an;
  logic          r_frameDone;
  logic          r_frameErr;

  logic [1:0]    w_normStatus;
  logic          w_capture;
  logic          w_commit;
  logic          w_errSet;
  logic [7:0]    w_blankNew;
  logic          w_allZero;
  scan_state_t   w_scanNext;
  logic [PW-1:0] w_prescNext;
  logic [2:0]    w_idxNext;
  logic [6:0]    w_segLow;
  logic [7:0]    w_anHigh;

  function automatic logic [6:0] hexToSeg(input logic [3:0] v);
    case (v)
      4'd0:    hexToSeg = 7'h40;
      4'd1:    hexToSeg = 7'h79;
      4'd2:    hexToSeg = 7'h24;
      4'd3:    hexToSeg = 7'h30;
      4'd4:    hexToSeg = 7'h19;
      4'd5:    hexToSeg = 7'h12;
      4'd6:    hexToSeg = 7'h02;
      4'd7:    hexToSeg = 7'h78;
      4'd8:    hexToSeg = 7'h00;
      4'd9:    hexToSeg = 7'h10;
      default: hexToSeg = 7'h3F;
    endcase
  endfunction

  // Reserved status 11 behaves exactly like ready.
  assign w_normStatus = (status == 2'b11) ? 2'b10 : status;
  assign w_errSet     = (w_normStatus == 2'b00);
  assign w_capture    = !r_errLatched && (w_normStatus == 2'b01) && (pos <= 4'd7);
  assign w_commit     = !r_errLatched && (r_prevStatus == 2'b01) && (w_normStatus == 2'b10);

  always_comb begin
    w_blankNew = 8'h00;
    w_allZero  = 1'b1;
`ifdef CALC_DISPLAY_ZERO_BLANK_EN
    for (int i = 7; i >= 1; i--) begin
      w_allZero     = w_allZero && (r_shadow[i] == 4'd0);
      w_blankNew[i] = w_allZero;
    end
`endif
  end

  always_comb begin
    w_scanNext  = r_scanState;
    w_prescNext = r_prescaler;
    w_idxNext   = r_scanIdx;
    case (r_scanState)
      SCAN_HOLD: begin
        w_prescNext = r_prescaler + PW'(1);
        if (r_prescaler == PRESC_PENULT) w_scanNext = SCAN_NEXT;
      end
      SCAN_NEXT: begin
        w_prescNext = '0;
        w_idxNext   = r_scanIdx + 3'd1;
        w_scanNext  = SCAN_HOLD;
      end
      default: w_scanNext = SCAN_HOLD;
    endcase
  end

  // Error mode overrides the frame with "Err" right-aligned on digits 2..0.
  always_comb begin
    w_anHigh = 8'b1 << r_scanIdx;
    w_segLow = 7'h7F;
    if (r_errLatched) begin
      case (r_scanIdx)
        3'd2:       w_segLow = 7'h06;
        3'd1, 3'd0: w_segLow = 7'h2F;
        default:    w_segLow = 7'h7F;
      endcase
    end else if (r_blank[r_scanIdx]) begin
      w_segLow = 7'h7F;
    end else begin
      w_segLow = hexToSeg(r_disp[r_scanIdx]);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < 8; i++) begin
        r_shadow[i] <= 4'd0;
        r_disp[i]   <= 4'd0;
      end
      r_blank      <= BLANK_RESET;
      r_wmask      <= 8'h00;
      r_prevStatus <= 2'b10;
      r_scanIdx    <= 3'd0;
      r_prescaler  <= '0;
      r_scanState  <= SCAN_HOLD;
      r_errLatched <= 1'b0;
      r_seg        <= SEG_BLANK_OUT;
      r_an         <= AN_OFF_OUT;
      r_frameDone  <= 1'b0;
      r_frameErr   <= 1'b0;
    end else begin
      r_prevStatus <= w_normStatus;
      r_frameDone  <= 1'b0;
      r_frameErr   <= 1'b0;
      if (w_errSet) r_errLatched <= 1'b1;
      if (w_capture) r_shadow[pos[2:0]] <= data;
      if (w_commit) begin
        if (&r_wmask) begin
          for (int i = 0; i < 8; i++) r_disp[i] <= r_shadow[i];
          r_blank     <= w_blankNew;
          r_frameDone <= 1'b1;
        end else begin
          r_frameErr <= 1'b1;
        end
        r_wmask <= 8'h00;
      end else if (w_capture) begin
        r_wmask[pos[2:0]] <= 1'b1;
      end
      r_scanState <= w_scanNext;
      r_prescaler <= w_prescNext;
      r_scanIdx   <= w_idxNext;
      r_seg       <= SEG_ACTIVE_LOW ? w_segLow : ~w_segLow;
      r_an        <= SEG_ACTIVE_LOW ? ~w_anHigh : w_anHigh;
    end
  end

  assign seg        = r_seg;
  assign an         = r_an;
  assign frame_done = r_frameDone;
  assign frame_err  = r_frameErr;
  assign err_led    = r_errLatched;

endmodule

// File: tb/tb_calc_display.sv
// Randomized scoreboard bench for calc_display; frame pulses are checked by a monitor against a queue.
// Display expectations come from a digit-level model of committed frames and error state.
module tb_calc_display;

  localparam int SCAN_DIV = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] status;
  logic [3:0] data;
  logic [3:0] pos;
  logic [6:0] seg;
  logic [7:0] an;
  logic       frame_done;
  logic       frame_err;
  logic       err_led;

  int checks = 0;
  int errors = 0;

  logic [1:0] expQ [$];
  logic [1:0] expFront;

  logic [3:0] mShadow [8];
  logic [3:0] mDisp   [8];
  logic [7:0] mMask;
  bit         mErr;
  bit         mPrevBusy;

  logic [6:0] segTab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};

  calc_display #(.SCAN_DIV(SCAN_DIV), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clock(clock), .reset(reset), .status(status), .data(data), .pos(pos),
    .seg(seg), .an(an), .frame_done(frame_done), .frame_err(frame_err), .err_led(err_led)
  );

  always #5 clock = ~clock;

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected active-low segments of digit i, from the committed digits and error state.
  function automatic logic [6:0] expSeg(input int i);
    bit lead;
    if (mErr) return (i == 2) ? 7'h06 : ((i < 2) ? 7'h2F : 7'h7F);
`ifdef CALC_DISPLAY_ZERO_BLANK_EN
    if (i > 0) begin
      lead = 1'b1;
      for (int j = i; j < 8; j++) if (mDisp[j] != 4'd0) lead = 1'b0;
      if (lead) return 7'h7F;
    end
`endif
    lead = 1'b0;
    return segTab[mDisp[i]];
  endfunction

  task automatic tick;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic applyStimulus(input logic [1:0] st, input logic [3:0] p, input logic [3:0] d);
    logic [1:0] ns;
    status = st;
    pos    = p;
    data   = d;
    ns = (st == 2'b11) ? 2'b10 : st;
    if (ns == 2'b00) begin
      mErr = 1'b1;
    end else if (!mErr) begin
      if (mPrevBusy && ns == 2'b10) begin
        if (mMask == 8'hFF) begin
          for (int i = 0; i < 8; i++) mDisp[i] = mShadow[i];
          expQ.push_back(2'b10);
        end else begin
          expQ.push_back(2'b01);
        end
        mMask = 8'h00;
      end
      if (ns == 2'b01 && p <= 4'd7) begin
        mShadow[p[2:0]] = d;
        mMask[p[2:0]]   = 1'b1;
      end
    end
    mPrevBusy = (ns == 2'b01);
    tick();
  endtask

  task automatic applyReset(input int cycles, input logic [1:0] st, input logic [3:0] p, input logic [3:0] d);
    reset  = 1'b0;
    status = st;
    pos    = p;
    data   = d;
    for (int i = 0; i < 8; i++) begin
      mShadow[i] = 4'd0;
      mDisp[i]   = 4'd0;
    end
    mMask = 8'h00;
    mErr = 1'b0;
    mPrevBusy = 1'b0;
    for (int c = 0; c < cycles; c++) tick();
    reset = 1'b1;
  endtask

  task automatic writeFrame(input logic [3:0] digits [8]);
    for (int i = 0; i < 8; i++) applyStimulus(2'b01, 4'(i), digits[i]);
  endtask

  // Idles in ready and watches one full scan, comparing each digit once.
  task automatic checkOutput;
    logic [7:0] seen;
    int idx;
    seen = 8'h00;
    applyStimulus(2'b10, 4'd0, 4'd0);
    applyStimulus(2'b10, 4'd0, 4'd0);
    for (int c = 0; c < 8 * SCAN_DIV + 2; c++) begin
      applyStimulus(2'b10, 4'd0, 4'd0);
      idx = -1;
      for (int i = 0; i < 8; i++) if (an == ~(8'b1 << i)) idx = i;
      if (idx < 0) begin
        checkValue("an_onehot", {24'd0, an}, 32'h0000_00FE);
      end else if (!seen[idx]) begin
        seen[idx] = 1'b1;
        checkValue($sformatf("seg_digit%0d", idx), {25'd0, seg}, {25'd0, expSeg(idx)});
      end
    end
    checkValue("scan_coverage", {24'd0, seen}, 32'h0000_00FF);
    checkValue("err_led", {31'd0, err_led}, {31'd0, mErr});
  endtask

  always @(negedge clock) begin
    if (frame_done || frame_err) begin
      if (expQ.size() == 0) begin
        checkValue("sb_unexpected_pulse", {30'd0, frame_done, frame_err}, 32'd0);
      end else begin
        expFront = expQ.pop_front();
        checkValue("sb_frame_pulse", {30'd0, frame_done, frame_err}, {30'd0, expFront});
      end
    end
  end

  initial begin
    logic [3:0] fr [8];
    int order [8];
    int mode, n, j, tmp;

    applyReset(3, 2'b10, 4'd0, 4'd0);
    checkValue("reset_an", {24'd0, an}, 32'hFF);
    checkValue("reset_seg", {25'd0, seg}, 32'h7F);
    checkValue("reset_err_led", {31'd0, err_led}, 32'd0);
    checkValue("reset_pulses", {30'd0, frame_done, frame_err}, 32'd0);
    applyStimulus(2'b10, 4'd0, 4'd0);
    checkValue("release_an", {24'd0, an}, 32'hFE);
    checkValue("release_seg", {25'd0, seg}, 32'h40);
    for (int c = 0; c < 4; c++) applyStimulus(2'b10, 4'd0, 4'd0);
    checkValue("scan_step_an", {24'd0, an}, 32'hFD);

    fr = '{4'd7, 4'd5, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    writeFrame(fr);
    applyStimulus(2'b10, 4'd0, 4'd0);
    checkOutput();

    for (int i = 0; i < 6; i++) applyStimulus(2'b01, 4'(i), 4'($urandom_range(0, 15)));
    applyStimulus(2'b10, 4'd0, 4'd0);
    checkOutput();
    for (int i = 0; i < 8; i++) fr[i] = 4'($urandom_range(0, 9));
    writeFrame(fr);
    applyStimulus(2'b11, 4'd0, 4'd0);
    checkOutput();

    fr = '{4'd3, 4'd1, 4'd4, 4'd12, 4'd5, 4'd9, 4'd2, 4'd6};
    for (int i = 0; i < 4; i++) applyStimulus(2'b01, 4'(i), fr[i]);
    applyStimulus(2'b01, 4'd8, 4'd9);
    for (int i = 4; i < 8; i++) applyStimulus(2'b01, 4'(i), fr[i]);
    applyStimulus(2'b01, 4'd15, 4'd0);
    applyStimulus(2'b10, 4'd0, 4'd0);
    checkOutput();

    for (int f = 0; f < 15; f++) begin
      mode = $urandom_range(0, 2);
      if (mode == 0) begin
        for (int i = 0; i < 8; i++) order[i] = i;
        for (int i = 7; i > 0; i--) begin
          j = $urandom_range(0, i);
          tmp = order[i]; order[i] = order[j]; order[j] = tmp;
        end
        for (int i = 0; i < 8; i++) begin
          applyStimulus(2'b01, 4'(order[i]), 4'($urandom_range(0, 15)));
          if ($urandom_range(0, 3) == 0) applyStimulus(2'b01, 4'($urandom_range(8, 15)), 4'($urandom_range(0, 15)));
        end
      end else if (mode == 1) begin
        n = $urandom_range(3, 12);
        for (int i = 0; i < n; i++) applyStimulus(2'b01, 4'($urandom_range(0, 9)), 4'($urandom_range(0, 15)));
      end else begin
        for (int i = 0; i < 8; i++) applyStimulus(2'b01, 4'(i), ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15)));
        applyStimulus(2'b01, 4'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
      end
      applyStimulus(($urandom_range(0, 1) == 0) ? 2'b10 : 2'b11, 4'd0, 4'd0);
      checkOutput();
    end

    for (int i = 0; i < 3; i++) applyStimulus(2'b01, 4'(i), 4'(i + 1));
    applyReset(1, 2'b01, 4'd3, 4'd4);
    for (int i = 4; i < 8; i++) applyStimulus(2'b01, 4'(i), 4'(i));
    applyStimulus(2'b10, 4'd0, 4'd0);
    checkOutput();

    fr = '{4'd8, 4'd6, 4'd4, 4'd2, 4'd1, 4'd3, 4'd5, 4'd7};
    writeFrame(fr);
    applyStimulus(2'b10, 4'd0, 4'd0);
    applyStimulus(2'b00, 4'd0, 4'd0);
    applyStimulus(2'b10, 4'd0, 4'd0);
    checkOutput();
    for (int i = 0; i < 8; i++) fr[i] = 4'($urandom_range(0, 9));
    writeFrame(fr);
    applyStimulus(2'b10, 4'd0, 4'd0);
    checkOutput();
    applyReset(2, 2'b10, 4'd0, 4'd0);
    checkOutput();

    for (int c = 0; c < 4; c++) applyStimulus(2'b10, 4'd0, 4'd0);
    checkValue("sb_drain", expQ.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
